// File: rtl/isa_pkg.sv
// Shared ISA definitions for the scalar ALU functional unit:
// operation encodings and the flag bundle that travels with each result.
package isa_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef struct packed {
        logic negative;
        logic overflow;
        logic zero;
        logic illegal;
    } alu_flags_t;

endpackage

// File: rtl/fu_alu_core.sv
// Combinational ALU datapath: maps an op code and two operands to a result
// plus its flags. Undefined op codes yield a zero result with illegal set.
module fu_alu_core
    import isa_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        aluop,
    input  logic [DATA_W-1:0] port_a,
    input  logic [DATA_W-1:0] port_b,
    output logic [DATA_W-1:0] result,
    output alu_flags_t        flags
);

    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    logic [SH_W-1:0] shamt;
    logic            ovf;
    logic            ill;

    assign shamt = port_b[SH_W-1:0];

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        ill    = 1'b0;
        case (aluop_t'(aluop))
            ALU_ADD: begin
                result = port_a + port_b;
                ovf    = (port_a[MSB] == port_b[MSB]) && (result[MSB] != port_a[MSB]);
            end
            ALU_SUB: begin
                result = port_a - port_b;
                ovf    = (port_a[MSB] != port_b[MSB]) && (result[MSB] != port_a[MSB]);
            end
            ALU_AND:  result = port_a & port_b;
            ALU_OR:   result = port_a | port_b;
            ALU_XOR:  result = port_a ^ port_b;
            ALU_SLL:  result = port_a << shamt;
            ALU_SRL:  result = port_a >> shamt;
            ALU_SRA:  result = $signed(port_a) >>> shamt;
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, $signed(port_a) < $signed(port_b)};
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, port_a < port_b};
            default:  ill    = 1'b1;
        endcase
    end

    assign flags.negative = result[MSB];
    assign flags.overflow = ovf;
    assign flags.zero     = (result == '0);
    assign flags.illegal  = ill;

endmodule

// File: rtl/fu_alu_pipe.sv
// Pipelined ALU functional unit: valid/ready on both sides, collapsing
// bubbles, flush of in-flight ops and a tag carried alongside each result.
module fu_alu_pipe
    import isa_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 aluop,
    input  logic [DATA_W-1:0]          port_a,
    input  logic [DATA_W-1:0]          port_b,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          port_output,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       negative,
    output logic                       overflow,
    output logic                       zero,
    output logic                       illegal,
    output logic [$clog2(STAGES+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] adv;
    logic [STAGES:0]   free;
    logic [DATA_W-1:0] res_q   [STAGES];
    alu_flags_t        flags_q [STAGES];
    logic [TAG_W-1:0]  tag_q   [STAGES];

    logic [DATA_W-1:0] core_res;
    alu_flags_t        core_flags;
    logic              in_fire;

    fu_alu_core #(.DATA_W(DATA_W)) u_core (
        .aluop  (aluop),
        .port_a (port_a),
        .port_b (port_b),
        .result (core_res),
        .flags  (core_flags)
    );

    // free[k]: stage k can take new contents this cycle; free[STAGES] is the consumer.
    always_comb begin
        adv          = '0;
        free         = '0;
        free[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k]  = valid_q[k] && free[k+1];
            free[k] = !valid_q[k] || adv[k];
        end
    end

    assign in_ready = !flush && free[0];
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k]   <= '0;
                flags_q[k] <= '0;
                tag_q[k]   <= '0;
            end
        end else begin
            if (flush) begin
                valid_q <= '0;
            end else begin
                if (free[0]) valid_q[0] <= in_fire;
                for (int k = 1; k < STAGES; k++) begin
                    if (free[k]) valid_q[k] <= valid_q[k-1];
                end
            end
            if (in_fire) begin
                res_q[0]   <= core_res;
                flags_q[0] <= core_flags;
                tag_q[0]   <= in_tag;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k-1]) begin
                    res_q[k]   <= res_q[k-1];
                    flags_q[k] <= flags_q[k-1];
                    tag_q[k]   <= tag_q[k-1];
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < STAGES; k++) begin
            occupancy = occupancy + OCC_W'(valid_q[k]);
        end
    end

    assign out_valid   = valid_q[STAGES-1];
    assign port_output = res_q[STAGES-1];
    assign out_tag     = tag_q[STAGES-1];
    assign negative    = flags_q[STAGES-1].negative;
    assign overflow    = flags_q[STAGES-1].overflow;
    assign zero        = flags_q[STAGES-1].zero;
    assign illegal     = flags_q[STAGES-1].illegal;

endmodule

// File: doc/fu_alu_pipe.md
Name: fu_alu_pipe

Overview:
- Parametrised, pipelined successor to the scalar combinational ALU functional unit.
- Adds a valid/ready handshake on both sides, configurable operand width and pipeline depth, and a tag passthrough for scoreboard writeback.
- Adds a flush that kills in-flight ops and an illegal-op flag.
- Sits between issue and writeback in the tensor-core scalar datapath.

Parameters:
- DATA_W, 32: operand/result width, >= 8, power of two.
- STAGES, 2: register stages from accept to output, >= 1.
- TAG_W, 5: destination tag width, carried unchanged.

Ports:
- CLK  input  1  clock
- RST  input  1  asynchronous, active-high reset
- flush  input  1  kill all in-flight and incoming ops this cycle
- in_valid  input  1  op offered
- in_ready  output  1  op accepted when in_valid && in_ready
- aluop  input  4  operation code (aluop_t)
- port_a  input  DATA_W  operand A
- port_b  input  DATA_W  operand B
- in_tag  input  TAG_W  destination tag
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- port_output  output  DATA_W  result
- out_tag  output  TAG_W  tag of the result
- negative  output  1  result MSB
- overflow  output  1  signed overflow (ADD/SUB only)
- zero  output  1  result == 0
- illegal  output  1  aluop not a defined encoding
- occupancy  output  $clog2(STAGES+1)  number of valid stages

Behaviour:
- Reset (asynchronous, RST high): all stage valids 0; out_valid=0, occupancy=0, port_output/out_tag/flags=0. in_ready=1 once RST is low.
- Ops: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9. Codes 10-15 are illegal: result 0, illegal=1, zero=1.
- Shift amount is port_b[$clog2(DATA_W)-1:0]. SLT/SLTU produce 1 or 0, zero-extended.
- Overflow for ADD: operands share a sign and the result sign differs. For SUB: operand signs differ and the result sign differs from A. Overflow is 0 for all other ops.
- Flags are computed combinationally in stage 0 and travel with the result.
- Pipeline: stage k holds {valid, result, flags, tag}.
  - Stage k advances when stage k+1 is empty or itself advances. The last stage advances when out_ready is high.
  - Bubbles collapse, i.e. a stalled downstream does not block upstream empty slots.
  - in_ready = !valid[0] || advance[0]. This is combinational from out_ready and must have no in_valid dependency.
- Latency: exactly STAGES cycles from accept to out_valid when there is no backpressure. Throughput is 1 op/cycle.
- Outputs are driven from the last stage. port_output, out_tag and the flags are held stable while out_valid && !out_ready.
- Flush:
  - On the next edge all valids clear and occupancy becomes 0.
  - in_ready is forced 0 during flush, so no op is accepted that cycle.
  - Flush with out_valid && out_ready in the same cycle: that output transfer completes and counts as delivered.
- occupancy = popcount of stage valids; range 0..STAGES.
- RST asserted mid-operation: all state clears immediately; no partial output.

Decomposition:
- Shared package (isa_pkg): aluop_t enum with the encodings above, and a typedef alu_flags_t {negative, overflow, zero, illegal}.
- Sub-module fu_alu_core: purely combinational, parametrised by DATA_W. It maps aluop, port_a and port_b to the result and alu_flags_t.
- fu_alu_pipe: handshake, stage registers, flush and occupancy.

Test Plan:
- DATA_W=32, STAGES=2: ADD 0x7FFFFFFF+1, tag 3 -> out_valid 2 cycles later, port_output=0x80000000, overflow=1, negative=1, out_tag=3.
- SUB 5-5 -> result 0, zero=1, overflow=0. SRA 0x80000000 by 0x21 -> shift 1, result 0xC0000000. SLTU 1<0xFFFFFFFF -> result 1.
- Back-to-back stream of 8 ADDs, out_ready=1 -> one result per cycle, in order, in_ready stays 1.
- out_ready held 0 for 5 cycles with a continuous input stream -> occupancy reaches 2, in_ready drops, output holds stable; on release all ops drain in order with no loss or duplicates.
- Two ops in flight, flush asserted with in_valid=1 -> in_ready=0 that cycle, next cycle occupancy=0 and out_valid=0; the dropped ops never appear.
- aluop=12 -> illegal=1, port_output=0, zero=1. RST pulsed with 2 ops in flight -> out_valid=0 immediately, occupancy=0.
